// File: rtl/rv_seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; start/valid handshake with flush abort.
module rv_seq_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              sel_rem_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;

  logic              is_signed;
  logic              dvd_neg;
  logic              dvs_neg;
  logic [XLEN-1:0]   dvd_mag;
  logic [XLEN-1:0]   dvs_mag;
  logic              div_zero;
  logic              sgn_ovf;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   quo_d;
  logic [XLEN-1:0]   rem_d;
  logic [XLEN-1:0]   result_d;

  // Operand decode at accept: magnitudes, signs and special cases
  always_comb begin
    is_signed = ~op_i[0];
    dvd_neg   = is_signed & dividend_i[XLEN-1];
    dvs_neg   = is_signed & divisor_i[XLEN-1];
    dvd_mag   = dvd_neg ? (XLEN'(0) - dividend_i) : dividend_i;
    dvs_mag   = dvs_neg ? (XLEN'(0) - divisor_i) : divisor_i;
    div_zero  = (divisor_i == '0);
    sgn_ovf   = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                && (divisor_i == '1);
  end

  // One restoring step; the shifted partial remainder keeps its carry-out bit
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
    rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    if (sel_rem_q) begin
      result_d = neg_rem_q ? (XLEN'(0) - rem_q) : rem_q;
    end else begin
      result_d = neg_quo_q ? (XLEN'(0) - quo_q) : quo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            sel_rem_q <= op_i[1];
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            dvs_q     <= dvs_mag;
            if (div_zero) begin
              // Quotient all ones, remainder is the raw dividend, no fixup
              quo_q     <= '1;
              rem_q     <= dividend_i;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= S_DONE;
            end else if (sgn_ovf) begin
              quo_q     <= {1'b1, {(XLEN-1){1'b0}}};
              rem_q     <= '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= S_DONE;
            end else begin
              quo_q     <= dvd_mag;
              rem_q     <= '0;
              neg_quo_q <= dvd_neg ^ dvs_neg;
              neg_rem_q <= dvd_neg;
              state_q   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!flush_i) begin
            result_q <= result_d;
            valid_q  <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_rv_seq_divider.sv
// Self-checking bench for rv_seq_divider: directed vectors, handshake
// corner cases, and randomized ops against a plain-arithmetic model.
module tb_rv_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  rv_seq_divider #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: RISC-V semantics via 64-bit arithmetic (truncating division)
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Wait up to 40 edges for valid; returns edges elapsed or -1 on timeout
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (valid_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b;
    step();
    start_i = 1'b0;
    check({name, " busy_at_accept"}, 32'(busy_o), 32'd1);
    wait_valid(lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, result_o, exp);
    check({name, " busy_at_valid"}, 32'(busy_o), 32'd0);
    step();
    check({name, " valid_single"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{"div_100_7",    OP_DIV,  32'd100,        32'd7,          32'h0000_000E, 33};
    vecs[1]  = '{"rem_100_7",    OP_REM,  32'd100,        32'd7,          32'd2,         33};
    vecs[2]  = '{"div_m100_7",   OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 33};
    vecs[3]  = '{"rem_m100_7",   OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE, 33};
    vecs[4]  = '{"rem_100_m7",   OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,         33};
    vecs[5]  = '{"divu_max_2",   OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF, 33};
    vecs[6]  = '{"remu_max_2",   OP_REMU, 32'hFFFF_FFFF,  32'd2,          32'd1,         33};
    vecs[7]  = '{"div_5_0",      OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF, 1};
    vecs[8]  = '{"remu_5_0",     OP_REMU, 32'd5,          32'd0,          32'd5,         1};
    vecs[9]  = '{"div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1};
    vecs[10] = '{"rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1};
    vecs[11] = '{"divu_max_max", OP_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,         33};

    rst_n = 1'b0; start_i = 1'b0; op_i = 2'b00; dividend_i = '0; divisor_i = '0; flush_i = 1'b0;
    step();
    step();
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset valid", 32'(valid_o), 32'd0);
    check("reset result", result_o, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Starts while busy are ignored
    start_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd100; divisor_i = 32'd7;
    step();
    start_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      start_i = (k == 5 || k == 10);
      if (k == 5) begin
        op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd1;
      end
      step();
      if (valid_o) begin
        lat = k;
        break;
      end
    end
    start_i = 1'b0;
    check("ignore latency", 32'(lat), 32'd33);
    check("ignore result", result_o, 32'h0000_000E);
    step();
    check("ignore no_queue busy", 32'(busy_o), 32'd0);

    // Back-to-back: accept in the valid cycle
    start_i = 1'b1; op_i = OP_REMU; dividend_i = 32'd50; divisor_i = 32'd7;
    step();
    start_i = 1'b0;
    wait_valid(lat);
    check("b2b first result", result_o, 32'd1);
    start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd9; divisor_i = 32'd3;
    step();
    start_i = 1'b0;
    check("b2b accept busy", 32'(busy_o), 32'd1);
    wait_valid(lat);
    check("b2b second latency", 32'(lat), 32'd33);
    check("b2b second result", result_o, 32'd3);
    step();

    // Flush at E0+10: no valid, result holds
    run_op("pre_flush", OP_REMU, 32'd50, 32'd7, 32'd1, 33);
    start_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd1000; divisor_i = 32'd3;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 9; k++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush busy", 32'(busy_o), 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid_o) pulses++;
    end
    check("flush no_valid", 32'(pulses), 32'd0);
    check("flush result_hold", result_o, 32'd1);
    run_op("post_flush_divu", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Flush together with start in IDLE
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd8; divisor_i = 32'd2;
    step();
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_start busy", 32'(busy_o), 32'd0);
    step();
    check("flush_start valid", 32'(valid_o), 32'd0);

    // Reset mid-operation at E0+20
    start_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd100; divisor_i = 32'd7;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 19; k++) step();
    rst_n = 1'b0;
    step();
    check("midreset busy", 32'(busy_o), 32'd0);
    check("midreset valid", 32'(valid_o), 32'd0);
    check("midreset result", result_o, 32'd0);
    rst_n = 1'b1;
    step();
    run_op("post_reset_div", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = $urandom();
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'h8000_0000;
        4: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op("random", rop, ra, rb, model(rop, ra, rb), model_lat(rop, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
